// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single data RAM (sync write, comb read).
// Port 0 has fixed priority, and port 1 is forced through after STARVE_LIMIT consecutive losses.
module ram_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              p_req,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_be,
  input  logic [DATA_WIDTH/8-1:0] p1_be,
  input  logic                    p0_we,
  input  logic                    p1_we,
  output logic [1:0]              p_gnt,
  output logic [1:0]              p_ack,
  output logic [DATA_WIDTH-1:0]   p_rdata,
  output logic [ADDR_WIDTH-1:0]   memory_address,
  output logic [DATA_WIDTH-1:0]   memory_write,
  output logic [DATA_WIDTH/8-1:0] memory_byte_enable,
  output logic                    memory_we,
  input  logic [DATA_WIDTH-1:0]   memory_out
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);

  // Handshake: a request is accepted in the cycle where p_req[i] and p_gnt[i]
  // are both high at the rising edge; the payload must be stable until then.
  // Exactly one p_ack[i] pulse follows each accepted request two cycles later.

  logic [CNT_WIDTH-1:0]  starve_cnt_q, starve_cnt_d;
  logic                  a_valid_q, a_valid_d;
  logic                  a_id_q, a_id_d;
  logic                  a_we_q, a_we_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
  logic [BE_WIDTH-1:0]   a_be_q, a_be_d;
  logic                  b_valid_q, b_valid_d;
  logic                  b_id_q, b_id_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  gnt0, gnt1, starve_at_limit;

  assign starve_at_limit = (starve_cnt_q == CNT_WIDTH'(STARVE_LIMIT));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt1 = p_req[1] & (~p_req[0] | starve_at_limit);
      gnt0 = p_req[0] & ~gnt1;
    end
  end

  assign p_gnt = {gnt1, gnt0};

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!p_req[1] || gnt1) begin
      starve_cnt_d = '0;
    end else if (gnt0 && !starve_at_limit) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Stage A keeps the last payload on idle cycles so memory_address holds.
  always_comb begin
    a_valid_d = gnt0 | gnt1;
    a_id_d    = a_id_q;
    a_we_d    = a_we_q;
    a_addr_d  = a_addr_q;
    a_wdata_d = a_wdata_q;
    a_be_d    = a_be_q;
    if (gnt1) begin
      a_id_d    = 1'b1;
      a_we_d    = p1_we;
      a_addr_d  = p1_addr;
      a_wdata_d = p1_wdata;
      a_be_d    = p1_be;
    end else if (gnt0) begin
      a_id_d    = 1'b0;
      a_we_d    = p0_we;
      a_addr_d  = p0_addr;
      a_wdata_d = p0_wdata;
      a_be_d    = p0_be;
    end
  end

  always_comb begin
    b_valid_d = a_valid_q;
    b_id_d    = a_id_q;
    b_rdata_d = (a_valid_q && !a_we_q) ? memory_out : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      a_valid_q    <= 1'b0;
      a_id_q       <= 1'b0;
      a_we_q       <= 1'b0;
      a_addr_q     <= '0;
      a_wdata_q    <= '0;
      a_be_q       <= '0;
      b_valid_q    <= 1'b0;
      b_id_q       <= 1'b0;
      b_rdata_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      a_valid_q    <= a_valid_d;
      a_id_q       <= a_id_d;
      a_we_q       <= a_we_d;
      a_addr_q     <= a_addr_d;
      a_wdata_q    <= a_wdata_d;
      a_be_q       <= a_be_d;
      b_valid_q    <= b_valid_d;
      b_id_q       <= b_id_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // Gating with rst drops a write or ack that is in flight when reset arrives.
  assign memory_address     = a_addr_q;
  assign memory_write       = a_wdata_q;
  assign memory_we          = a_valid_q & a_we_q & ~rst;
  assign memory_byte_enable = memory_we ? a_be_q : '0;

  assign p_ack   = (b_valid_q && !rst) ? (b_id_q ? 2'b10 : 2'b01) : 2'b00;
  assign p_rdata = b_rdata_q;

endmodule
